xor_stream_unit: RTL and testbench
==================================

// Module: xor_stream_unit
// PURPOSE
// - Streaming, parametrised successor to the 1-bit XOR gate: WIDTH-bit Y = A ^ B per word, registered.
// - Valid/ready handshake in and out; per-frame XOR fold and parity of all results in a frame.
// - Sits between a word source and a checker/sink; frames are delimited by in_last or by reaching FRAME_MAX.
// PARAMETERS
// - WIDTH      8   data width of A, B, Y, frame_xor
// - FRAME_MAX  16  max words per frame (>=2); CW = $clog2(FRAME_MAX+1) = word_cnt width
// PORTS
// - clk          in   1      single clock; all logic on rising edge
// - rst_n        in   1      synchronous, active-low reset
// - in_valid     in   1      A/B/in_last valid
// - in_ready     out  1      unit can accept a word this cycle
// - A            in   WIDTH  operand A
// - B            in   WIDTH  operand B
// - in_last      in   1      word is last of frame
// - out_valid    out  1      Y/out_last valid
// - out_ready    in   1      sink accepts Y this cycle
// - Y            out  WIDTH  registered result
// - out_last     out  1      Y is last word of frame (user last or forced)
// - frame_xor    out  WIDTH  XOR fold of every Y in the completed frame
// - frame_parity out  1      ^frame_xor
// - frame_done   out  1      1-cycle pulse: frame_xor/frame_parity updated
// - word_cnt     out  CW     words accepted in current frame
// - frame_ovf    out  1      sticky: a frame was force-closed at FRAME_MAX; cleared only by reset
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): out_valid=0, Y=0, out_last=0, frame_xor=0, frame_parity=0,
//   frame_done=0, word_cnt=0, frame_ovf=0, state=IDLE. in_ready=1 in the cycle after reset.
// - Reset mid-frame discards the partial frame and any held Y; no frame_done is produced.
// - Accept = in_valid & in_ready. in_ready = ~out_valid | out_ready (combinational, 1-entry output reg).
// - Latency 1: accepted word appears on Y with out_valid=1 next cycle; full throughput 1 word/cycle.
// - Held output: while out_valid & ~out_ready, Y/out_last stable, in_ready=0, no accept.
// - Simultaneous out_ready & accept: old Y retires, new Y loads same edge; out_valid stays 1.
// - FSM: IDLE -> ACCUM on first accept (acc <= Y_new, word_cnt=1);
//   ACCUM: each accept acc ^= Y_new, word_cnt++;
//   close when accepted word has in_last=1, or word_cnt reaches FRAME_MAX (forced: out_last=1, frame_ovf<=1);
//   close -> DONE: frame_xor<=final acc, frame_parity<=^final acc, frame_done=1 for exactly 1 cycle,
//   word_cnt<=0; DONE -> IDLE unconditionally (DONE may also accept a word: it starts the next frame, ACCUM).
// - Single-word frame (in_last on first word) is legal: frame_xor = that Y.
// - frame_xor/frame_parity hold until the next frame closes; pulse coincides with out_valid of last Y.
// - in_last on a forced-close word is absorbed (no empty frame follows).
// - Y width exactly WIDTH; no carries/extension. word_cnt never exceeds FRAME_MAX.
// CONFIGURATION
// - XOR_XNOR_MODE_EN defined: extra input port `xnor_mode` (1 bit), sampled at accept;
//   Y = xnor_mode ? ~(A ^ B) : (A ^ B); fold uses the produced Y.
// - Not defined: port absent, Y = A ^ B always.
// TESTING (WIDTH=8, FRAME_MAX=4)
// - Reset: hold rst_n=0 3 cycles with in_valid=1 -> all outputs 0, no accept; release -> in_ready=1.
// - Frame A/B = (0x0F,0xF0),(0xAA,0x55),(0x3C,0x3C last), out_ready=1 -> Y=0xFF,0xFF,0x00 at 1-cycle
//   latency; frame_xor=0x00, frame_parity=0, frame_done 1 cycle with out_last.
// - Backpressure: out_ready=0 for 3 cycles after Y=0x01 -> Y/out_valid stable, in_ready=0; release -> no loss/dup.
// - Overflow: 5 words (0x01,0x00)x5 no in_last -> 4th word out_last=1, frame_ovf=1, frame_xor=0x00;
//   5th word starts new frame with word_cnt=1.
// - Reset mid-frame after 2 words -> word_cnt=0, out_valid=0, no frame_done; next frame folds from zero.
// - XOR_XNOR_MODE_EN: (0x0F,0x0F) xnor_mode=1 last -> Y=0xFF, frame_xor=0xFF, frame_parity=0.

Source files
------------

// File: rtl/xor_stream_unit.sv
`default_nettype none
// ============================================================================
// Module   : xor_stream_unit
// Purpose  : Streaming WIDTH-bit XOR unit. Each accepted word produces
//            Y = A ^ B one cycle later, behind a valid/ready handshake with a
//            single-entry output register. Results are grouped into frames
//            delimited by in_last or by reaching FRAME_MAX words; when a frame
//            closes, its XOR fold and parity are published with a 1-cycle
//            frame_done pulse.
// Config   : XOR_XNOR_MODE_EN - adds input xnor_mode; when high at accept the
//            word produces Y = ~(A ^ B). Undefined: Y = A ^ B always.
// Ports    : clk, rst_n (sync, active-low)
//            in_valid/in_ready/A/B/in_last     - input stream
//            [xnor_mode]                       - optional per-word inversion
//            out_valid/out_ready/Y/out_last    - output stream
//            frame_xor/frame_parity/frame_done - completed-frame summary
//            word_cnt                          - words accepted in open frame
//            frame_ovf                         - sticky forced-close flag
// Revision : 1.0 - initial release
// ============================================================================
module xor_stream_unit #(
    parameter int  WIDTH     = 8,
    parameter int  FRAME_MAX = 16,
    localparam int CW        = $clog2(FRAME_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_last,
`ifdef XOR_XNOR_MODE_EN
    input  logic             xnor_mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             out_last,
    output logic [WIDTH-1:0] frame_xor,
    output logic             frame_parity,
    output logic             frame_done,
    output logic [CW-1:0]    word_cnt,
    output logic             frame_ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [WIDTH-1:0]   acc, acc_d;
    logic [WIDTH-1:0]   y_d, frame_xor_d;
    logic               out_valid_d, out_last_d, frame_parity_d, frame_done_d, frame_ovf_d;
    logic [CW-1:0]      word_cnt_d, cnt_inc;
    logic [WIDTH-1:0]   y_new, acc_new;
    logic               accept, hit_max, close;

    // The output register can take a new word when empty or when its current
    // word retires this cycle. Held low during reset so nothing is accepted.
    assign in_ready = rst_n & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

`ifdef XOR_XNOR_MODE_EN
    assign y_new = xnor_mode ? ~(A ^ B) : (A ^ B);
`else
    assign y_new = A ^ B;
`endif

    // word_cnt is zero outside ACCUM, so the increment also covers a frame's
    // first word. It never exceeds FRAME_MAX because reaching it closes.
    assign cnt_inc = word_cnt + CW'(1);
    assign hit_max = (cnt_inc == CW'(FRAME_MAX));
    assign acc_new = (state == S_ACCUM) ? (acc ^ y_new) : y_new;
    assign close   = accept & (in_last | hit_max);

    always_comb begin
        state_d        = state;
        acc_d          = acc;
        y_d            = Y;
        out_valid_d    = out_valid;
        out_last_d     = out_last;
        frame_xor_d    = frame_xor;
        frame_parity_d = frame_parity;
        frame_done_d   = 1'b0;
        word_cnt_d     = word_cnt;
        frame_ovf_d    = frame_ovf;

        if (state == S_DONE) begin
            state_d = S_IDLE;
        end

        if (accept) begin
            y_d         = y_new;
            out_valid_d = 1'b1;
            // A word landing on FRAME_MAX is forced last; any in_last on it
            // is absorbed by the same close.
            out_last_d  = in_last | hit_max;
            if (close) begin
                state_d        = S_DONE;
                frame_xor_d    = acc_new;
                frame_parity_d = ^acc_new;
                frame_done_d   = 1'b1;
                word_cnt_d     = '0;
                acc_d          = '0;
                if (hit_max) begin
                    frame_ovf_d = 1'b1;
                end
            end else begin
                state_d    = S_ACCUM;
                acc_d      = acc_new;
                word_cnt_d = cnt_inc;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            acc          <= '0;
            Y            <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            frame_xor    <= '0;
            frame_parity <= 1'b0;
            frame_done   <= 1'b0;
            word_cnt     <= '0;
            frame_ovf    <= 1'b0;
        end else begin
            state        <= state_d;
            acc          <= acc_d;
            Y            <= y_d;
            out_valid    <= out_valid_d;
            out_last     <= out_last_d;
            frame_xor    <= frame_xor_d;
            frame_parity <= frame_parity_d;
            frame_done   <= frame_done_d;
            word_cnt     <= word_cnt_d;
            frame_ovf    <= frame_ovf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xor_stream_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_xor_stream_unit
// Purpose  : Self-checking bench for xor_stream_unit (WIDTH=8, FRAME_MAX=4).
//            A queue-based frame model predicts every output each cycle;
//            directed sequences add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xor_stream_unit;
    localparam int W  = 8;
    localparam int FM = 4;
    localparam int CW = $clog2(FM + 1);

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_ready, in_last, xnor_mode;
    logic [W-1:0]  A, B, Y, frame_xor;
    logic          out_valid, out_ready, out_last, frame_parity, frame_done, frame_ovf;
    logic [CW-1:0] word_cnt;

    always #5 clk = ~clk;

    xor_stream_unit #(.WIDTH(W), .FRAME_MAX(FM)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .in_last(in_last),
`ifdef XOR_XNOR_MODE_EN
        .xnor_mode(xnor_mode),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .Y(Y), .out_last(out_last),
        .frame_xor(frame_xor), .frame_parity(frame_parity), .frame_done(frame_done),
        .word_cnt(word_cnt), .frame_ovf(frame_ovf)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: words of the open frame kept in a queue.
    logic [W-1:0] frame_q[$];
    logic         m_valid, m_last, m_fp, m_done, m_ovf;
    logic [W-1:0] m_y, m_fx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] fold(input logic [W-1:0] q[$]);
        logic [W-1:0] f = '0;
        foreach (q[i]) f = f ^ q[i];
        return f;
    endfunction

    task automatic compare_all();
        chk("out_valid",    32'(out_valid),    32'(m_valid));
        chk("Y",            32'(Y),            32'(m_y));
        chk("out_last",     32'(out_last),     32'(m_last));
        chk("frame_xor",    32'(frame_xor),    32'(m_fx));
        chk("frame_parity", 32'(frame_parity), 32'(m_fp));
        chk("frame_done",   32'(frame_done),   32'(m_done));
        chk("word_cnt",     32'(word_cnt),     32'(frame_q.size()));
        chk("frame_ovf",    32'(frame_ovf),    32'(m_ovf));
    endtask

    // Drive one cycle of inputs, predict the next state, check after the edge.
    task automatic cycle(input bit r, input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit l, input bit o, input bit x);
        bit rdy, xm;
        logic [W-1:0] y;
        rst_n = r; in_valid = v; A = a; B = b; in_last = l; out_ready = o; xnor_mode = x;
`ifdef XOR_XNOR_MODE_EN
        xm = x;
`else
        xm = 1'b0;
`endif
        #1;
        rdy = r && (!m_valid || o);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        m_done = 1'b0;
        if (!r) begin
            frame_q.delete();
            m_valid = 0; m_last = 0; m_fp = 0; m_ovf = 0; m_y = '0; m_fx = '0;
        end else if (v && rdy) begin
            y = xm ? ~(a ^ b) : (a ^ b);
            frame_q.push_back(y);
            m_y = y; m_valid = 1'b1;
            m_last = l || (frame_q.size() == FM);
            if (frame_q.size() == FM) m_ovf = 1'b1;
            if (m_last) begin
                m_fx = fold(frame_q);
                m_fp = ^m_fx;
                m_done = 1'b1;
                frame_q.delete();
            end
        end else if (o) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        m_valid = 0; m_last = 0; m_fp = 0; m_done = 0; m_ovf = 0; m_y = '0; m_fx = '0;
        rst_n = 0; in_valid = 0; A = '0; B = '0; in_last = 0; out_ready = 0; xnor_mode = 0;
        @(negedge clk);

        // Reset held with in_valid high: nothing accepted, everything zero.
        repeat (3) cycle(0, 1, 8'h12, 8'h34, 0, 1, 0);
        chk("lit_rst_valid", 32'(out_valid), 32'h0);
        chk("lit_rst_cnt",   32'(word_cnt),  32'h0);
        rst_n = 1; in_valid = 0; #1;
        chk("lit_rst_ready", 32'(in_ready), 32'h1);

        // Basic frame of three words.
        cycle(1, 1, 8'h0F, 8'hF0, 0, 1, 0);
        chk("lit_y0", 32'(Y), 32'hFF);
        cycle(1, 1, 8'hAA, 8'h55, 0, 1, 0);
        chk("lit_y1", 32'(Y), 32'hFF);
        cycle(1, 1, 8'h3C, 8'h3C, 1, 1, 0);
        chk("lit_y2",    32'(Y),          32'h00);
        chk("lit_last2", 32'(out_last),   32'h1);
        chk("lit_done2", 32'(frame_done), 32'h1);
        chk("lit_fx2",   32'(frame_xor),  32'h00);
        chk("lit_fp2",   32'(frame_parity), 32'h0);
        cycle(1, 0, 8'h00, 8'h00, 0, 1, 0);
        chk("lit_done_pulse", 32'(frame_done), 32'h0);

        // Backpressure: Y=0x01 held for three cycles.
        cycle(1, 1, 8'h01, 8'h00, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 8'h02, 8'h00, 1, 0, 0);
            chk("lit_bp_y",     32'(Y),         32'h01);
            chk("lit_bp_valid", 32'(out_valid), 32'h1);
            chk("lit_bp_ready", 32'(in_ready),  32'h0);
        end
        cycle(1, 1, 8'h02, 8'h00, 1, 1, 0);
        chk("lit_bp_next", 32'(Y), 32'h02);
        cycle(1, 0, 8'h00, 8'h00, 0, 1, 0);

        // Overflow: five words without in_last.
        for (int i = 0; i < 4; i++) cycle(1, 1, 8'h01, 8'h00, 0, 1, 0);
        chk("lit_ovf_last", 32'(out_last),  32'h1);
        chk("lit_ovf_flag", 32'(frame_ovf), 32'h1);
        chk("lit_ovf_fx",   32'(frame_xor), 32'h00);
        chk("lit_ovf_cnt",  32'(word_cnt),  32'h0);
        cycle(1, 1, 8'h01, 8'h00, 0, 1, 0);
        chk("lit_ovf_next", 32'(word_cnt),  32'h1);

        // Reset mid-frame (now two words in), then a fresh frame.
        cycle(1, 1, 8'h07, 8'h00, 0, 1, 0);
        cycle(0, 1, 8'h07, 8'h00, 0, 1, 0);
        chk("lit_mid_cnt",   32'(word_cnt),   32'h0);
        chk("lit_mid_valid", 32'(out_valid),  32'h0);
        chk("lit_mid_done",  32'(frame_done), 32'h0);
        chk("lit_mid_ovf",   32'(frame_ovf),  32'h0);
        cycle(1, 1, 8'h05, 8'h00, 0, 1, 0);
        cycle(1, 1, 8'h00, 8'h03, 1, 1, 0);
        chk("lit_mid_fx", 32'(frame_xor), 32'h06);
        chk("lit_mid_fp", 32'(frame_parity), 32'h0);

`ifdef XOR_XNOR_MODE_EN
        cycle(1, 1, 8'h0F, 8'h0F, 1, 1, 1);
        chk("lit_xnor_y",  32'(Y),            32'hFF);
        chk("lit_xnor_fx", 32'(frame_xor),    32'hFF);
        chk("lit_xnor_fp", 32'(frame_parity), 32'h0);
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 3) != 0),
                  8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
